// File: rtl/display_scan.sv
// display_scan
//   Time-multiplexed driver for a 4-digit, common-anode 7-segment display.
//   A prescaler divides clk down to one digit slot every PRESCALE cycles and
//   the scan position walks 0,1,2,3,0,...  New values are captured into a
//   shadow register on load and only copied to the visible display register
//   at the end of a frame, so a frame never shows a mix of old and new data.
//
// Parameters
//   PRESCALE   clock cycles per digit slot (2 .. 2**24)
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous active-high reset
//   value      16-bit value, four hex digits, digit k = value[4k+3:4k]
//   load       one-cycle request to capture value
//   blank_lz   1 = blank leading zeros (digit 0 always lit)
//   anodes     active-low one-hot digit enable
//   segments   active-low segments {g,f,e,d,c,b,a}
//   digit_idx  current scan position
//   pending    a captured value is waiting for the next frame boundary
//   frame_done one-cycle pulse following each end-of-frame tick

module display_scan #(
    parameter int unsigned PRESCALE = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  anodes,
    output logic [6:0]  segments,
    output logic [1:0]  digit_idx,
    output logic        pending,
    output logic        frame_done
);

    localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] prescaler;
    logic [15:0]   shadow;
    logic [15:0]   disp;
    logic          tick;
    logic          commit;

    assign tick   = (prescaler == LAST);
    // End of frame: last slot of digit 3 is expiring.
    assign commit = tick && (digit_idx == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler  <= '0;
            digit_idx  <= '0;
            shadow     <= '0;
            disp       <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            prescaler  <= tick ? '0 : prescaler + PW'(1);
            frame_done <= commit;

            if (tick) begin
                digit_idx <= digit_idx + 2'd1;
            end

            // A load landing on the commit edge bypasses the shadow so the
            // newest value is shown in the very next frame.
            if (commit && load) begin
                disp    <= value;
                shadow  <= value;
                pending <= 1'b0;
            end else begin
                if (commit && pending) begin
                    disp    <= shadow;
                    pending <= 1'b0;
                end
                if (load) begin
                    shadow  <= value;
                    pending <= 1'b1;
                end
            end
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    logic [3:0] nibble;
    logic       upper_zero;

    always_comb begin
        nibble = disp[{digit_idx, 2'b00} +: 4];
        // True when this digit and every more-significant digit are zero;
        // digit 0 is never treated as a leading zero.
        case (digit_idx)
            2'd1:    upper_zero = (disp[15:4]  == '0);
            2'd2:    upper_zero = (disp[15:8]  == '0);
            2'd3:    upper_zero = (disp[15:12] == '0);
            default: upper_zero = 1'b0;
        endcase
    end

    always_comb begin
        anodes = ~(4'b0001 << digit_idx);
        if (blank_lz && upper_zero) begin
            segments = '1;
        end else begin
            segments = hex7(nibble);
        end
    end

endmodule
